// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between two byte FIFOs with round-robin selection.
// Latency: a byte written into an empty FIFO while idle is popped next edge; tx_start the cycle after.
// Backpressure: reqN_full when a FIFO holds DEPTH bytes; writes while full are dropped and flagged in reqN_ovf.

// Per-requester byte FIFO with a sticky overflow flag.
// A write while full is rejected even if a pop happens the same cycle.
module uart_tx_arb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  input  logic       ovf_clr_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          wr_ok;
  logic          pop_ok;

  // Full/empty come straight from the registered count, so they lag a write or pop by one edge.
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign ovf_o   = ovf_q;

  assign wr_ok  = wr_i && !full_o;
  assign pop_ok = pop_i && !empty_o;

  // Next pointers, count and overflow flag; a fresh overflow wins over a same-cycle clear.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = (ovf_q && !ovf_clr_i) || (wr_i && full_o);
  end

  // Control state with synchronous reset; reset discards all queued bytes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

module uart_tx_arbiter #(
  parameter int DEPTH    = 4,
  parameter int GAP_CLKS = 16
) (
  input  logic       CLK50M,
  input  logic       RST,
  input  logic [7:0] req0_data,
  input  logic       req0_wr,
  output logic       req0_full,
  output logic       req0_ovf,
  input  logic [7:0] req1_data,
  input  logic       req1_wr,
  output logic       req1_full,
  output logic       req1_ovf,
  input  logic       ovf_clr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       active
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  // Gap counter counts GAP_CLKS-1 down to 0, so it needs room for GAP_CLKS-1 only.
  localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int GAP_LOAD = (GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    txd_q, txd_d;
  logic          gid_q, gid_d;
  logic          last_q, last_d;

  logic [7:0] head0, head1;
  logic       empty0, empty1;
  logic       pop0, pop1;
  logic       sel;

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk_i     (CLK50M),
    .rst_i     (RST),
    .wr_i      (req0_wr),
    .wdata_i   (req0_data),
    .pop_i     (pop0),
    .ovf_clr_i (ovf_clr),
    .head_o    (head0),
    .empty_o   (empty0),
    .full_o    (req0_full),
    .ovf_o     (req0_ovf)
  );

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_i     (CLK50M),
    .rst_i     (RST),
    .wr_i      (req1_wr),
    .wdata_i   (req1_data),
    .pop_i     (pop1),
    .ovf_clr_i (ovf_clr),
    .head_o    (head1),
    .empty_o   (empty1),
    .full_o    (req1_full),
    .ovf_o     (req1_ovf)
  );

  // On a tie the requester that was not served last wins; otherwise the only non-empty one.
  assign sel = (!empty0 && !empty1) ? !last_q : empty0;

  assign tx_data  = txd_q;
  assign grant_id = gid_q;
  assign active   = (state_q != S_IDLE);

  // Next-state, pop and start-pulse decode for the transmit sequencer.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    txd_d    = txd_q;
    gid_d    = gid_q;
    last_d   = last_q;
    pop0     = 1'b0;
    pop1     = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty0 || !empty1) begin
          pop0    = !sel;
          pop1    = sel;
          txd_d   = sel ? head1 : head0;
          gid_d   = sel;
          last_d  = sel;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_start = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // No timeout and no re-issue: a TX core that never goes busy parks us here.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CLKS == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GW'(GAP_LOAD);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any frame in flight and re-arms requester 0 for the first tie.
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      txd_q   <= 8'h00;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random and directed traffic against a queue-based reference model.
// The model predicts pops from frame timing (pop, start, busy length, one detect cycle, gap).
// A second instance with GAP_CLKS=0 checks the zero-gap restart spacing.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;

  logic       CLK50M = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] req0_data = 8'h00;
  logic       req0_wr = 1'b0;
  logic       req0_full, req0_ovf;
  logic [7:0] req1_data = 8'h00;
  logic       req1_wr = 1'b0;
  logic       req1_full, req1_ovf;
  logic       ovf_clr = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       grant_id, active;

  logic       g0_RST = 1'b1;
  logic [7:0] g0_req0_data = 8'h00;
  logic       g0_req0_wr = 1'b0;
  logic       g0_req0_full, g0_req0_ovf, g0_req1_full, g0_req1_ovf;
  logic [7:0] g0_tx_data;
  logic       g0_tx_start;
  logic       g0_tx_busy = 1'b0;
  logic       g0_grant_id, g0_active;

  always #10 CLK50M = ~CLK50M;

  uart_tx_arbiter #(.DEPTH(DEPTH), .GAP_CLKS(GAP)) u_dut (
    .CLK50M(CLK50M), .RST(RST),
    .req0_data(req0_data), .req0_wr(req0_wr), .req0_full(req0_full), .req0_ovf(req0_ovf),
    .req1_data(req1_data), .req1_wr(req1_wr), .req1_full(req1_full), .req1_ovf(req1_ovf),
    .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active)
  );

  uart_tx_arbiter #(.DEPTH(DEPTH), .GAP_CLKS(0)) u_dut_gap0 (
    .CLK50M(CLK50M), .RST(g0_RST),
    .req0_data(g0_req0_data), .req0_wr(g0_req0_wr), .req0_full(g0_req0_full), .req0_ovf(g0_req0_ovf),
    .req1_data(8'h00), .req1_wr(1'b0), .req1_full(g0_req1_full), .req1_ovf(g0_req1_ovf),
    .ovf_clr(1'b0), .tx_data(g0_tx_data), .tx_start(g0_tx_start), .tx_busy(g0_tx_busy),
    .grant_id(g0_grant_id), .active(g0_active)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;

  // Reference model state
  logic [7:0] q0_m[$];
  logic [7:0] q1_m[$];
  bit         ovf0_m = 0, ovf1_m = 0, lastg_m = 1, gid_m = 0;
  logic [7:0] txd_m = 8'h00;
  int         free_at = 0;
  int         cur_start = -100000;
  int         cur_t = 0;
  int         t_min = 1, t_max = 24;

  logic [8:0] dut_sent[$];
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_len"}, 32'(dut_sent.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq(tag, (i < dut_sent.size()) ? 32'(dut_sent[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  // One clock cycle: compare outputs, drive inputs (and the TX core's busy), advance the model.
  task automatic step(input bit rst, input bit w0, input logic [7:0] d0,
                      input bit w1, input logic [7:0] d1, input bit clr);
    bit f0, f1, sel;
    check_eq("tx_start",  32'(tx_start),  32'(c == cur_start));
    check_eq("tx_data",   32'(tx_data),   32'(txd_m));
    check_eq("grant_id",  32'(grant_id),  32'(gid_m));
    check_eq("active",    32'(active),    32'(c < free_at));
    check_eq("req0_full", 32'(req0_full), 32'(q0_m.size() == DEPTH));
    check_eq("req1_full", 32'(req1_full), 32'(q1_m.size() == DEPTH));
    check_eq("req0_ovf",  32'(req0_ovf),  32'(ovf0_m));
    check_eq("req1_ovf",  32'(req1_ovf),  32'(ovf1_m));
    if (tx_start === 1'b1) dut_sent.push_back({grant_id, tx_data});

    RST       = rst;
    req0_wr   = w0;
    req0_data = d0;
    req1_wr   = w1;
    req1_data = d1;
    ovf_clr   = clr;
    tx_busy   = (c > cur_start) && (c <= cur_start + cur_t);

    if (rst) begin
      q0_m.delete();
      q1_m.delete();
      ovf0_m = 0; ovf1_m = 0; lastg_m = 1; gid_m = 0; txd_m = 8'h00;
      free_at = c + 1; cur_start = -100000; cur_t = 0;
    end else begin
      f0 = (q0_m.size() == DEPTH);
      f1 = (q1_m.size() == DEPTH);
      if (c >= free_at && (q0_m.size() != 0 || q1_m.size() != 0)) begin
        if (q0_m.size() != 0 && q1_m.size() != 0) sel = !lastg_m;
        else sel = (q0_m.size() == 0);
        txd_m = sel ? q1_m.pop_front() : q0_m.pop_front();
        gid_m = sel; lastg_m = sel;
        cur_start = c + 1;
        cur_t = int'($urandom_range(t_max, t_min));
        // pop, start, busy frame, one cycle to see busy low, then the gap
        free_at = c + cur_t + 3 + GAP;
      end
      if (w0 && !f0) q0_m.push_back(d0);
      if (w1 && !f1) q1_m.push_back(d1);
      ovf0_m = (ovf0_m && !clr) || (w0 && f0);
      ovf1_m = (ovf1_m && !clr) || (w1 && f1);
    end
    @(posedge CLK50M);
    c++;
    @(negedge CLK50M);
  endtask

  task automatic idle_step();
    step(0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic reset2();
    step(1, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (!(c >= free_at && q0_m.size() == 0 && q1_m.size() == 0) && n < max_cyc) begin
      idle_step();
      n++;
    end
    idle_step();
    check_eq("drain_bound", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, s1, s2;
    logic [7:0] gd1, gd2;
    repeat (2) @(posedge CLK50M);
    @(negedge CLK50M);

    // Random traffic in segments of varying write density
    for (int seg = 0; seg < 20; seg++) begin
      p0 = int'($urandom_range(40, 0));
      p1 = int'($urandom_range(40, 0));
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(599, 0) == 0,
             int'($urandom_range(99, 0)) < p0, 8'($urandom),
             int'($urandom_range(99, 0)) < p1, 8'($urandom),
             $urandom_range(39, 0) == 0);
      end
    end
    drain(3000);

    // Single byte, 16-cycle frame
    t_min = 16; t_max = 16;
    reset2();
    dut_sent.delete();
    step(0, 1, 8'h41, 0, 8'h00, 0);
    drain(200);
    exp_q = {9'h041};
    check_seq("single");

    // Round-robin tie from reset
    reset2();
    dut_sent.delete();
    step(0, 1, 8'h10, 1, 8'h20, 0);
    step(0, 1, 8'h11, 1, 8'h21, 0);
    drain(500);
    exp_q = {9'h010, 9'h120, 9'h011, 9'h121};
    check_seq("rr");

    // Overflow while the TX core is stalled busy
    t_min = 150; t_max = 150;
    reset2();
    dut_sent.delete();
    step(0, 1, 8'h99, 0, 8'h00, 0);
    repeat (4) idle_step();
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 8'hA0 + 8'(i), 0);
    check_eq("ovf1_set", 32'(req1_ovf), 32'd1);
    check_eq("full1_set", 32'(req1_full), 32'd1);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    check_eq("ovf1_clr", 32'(req1_ovf), 32'd0);
    t_min = 16; t_max = 16;
    drain(1000);
    exp_q = {9'h099, 9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};
    check_seq("ovf");

    // Write into FIFO0 in the same cycle its only byte is popped
    reset2();
    dut_sent.delete();
    step(0, 1, 8'h55, 0, 8'h00, 0);
    step(0, 1, 8'h66, 0, 8'h00, 0);
    drain(200);
    exp_q = {9'h055, 9'h066};
    check_seq("wr_pop");

    // Reset in the middle of WAIT_DONE with three bytes queued
    t_min = 20; t_max = 20;
    reset2();
    for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0, 8'h00, 0);
    repeat (2) idle_step();
    reset2();
    dut_sent.delete();
    repeat (80) idle_step();
    check_eq("post_rst_starts", 32'(dut_sent.size()), 32'd0);
    step(0, 1, 8'h77, 0, 8'h00, 0);
    drain(200);
    exp_q = {9'h077};
    check_seq("post_rst");

    // Zero-gap instance: two queued bytes, 5-cycle frames
    s1 = -1; s2 = -1; gd1 = 8'h00; gd2 = 8'h00;
    for (int k = 0; k < 100 && s2 < 0; k++) begin
      if (g0_tx_start === 1'b1) begin
        if (s1 < 0) begin s1 = k; gd1 = g0_tx_data; end
        else begin s2 = k; gd2 = g0_tx_data; end
      end
      g0_RST       = 1'b0;
      g0_req0_wr   = (k < 2);
      g0_req0_data = (k == 0) ? 8'h31 : 8'h32;
      g0_tx_busy   = (s1 >= 0) && (k > s1) && (k <= s1 + 5);
      @(posedge CLK50M);
      @(negedge CLK50M);
    end
    check_eq("gap0_first_start", 32'(s1), 32'd2);
    check_eq("gap0_first_data", 32'(gd1), 32'h31);
    check_eq("gap0_second_data", 32'(gd2), 32'h32);
    check_eq("gap0_spacing", 32'(s2 - (s1 + 6)), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
